// File: rtl/wb_arbiter.sv
// Write-back arbiter for the register file's single write port.
// Merges the fixed-latency ALU result (port A) with the variable-latency
// load/mul-div result (port B, held in a small skid FIFO) into one registered
// write stream. A scoreboard tracks pending long-latency destinations so the
// issue stage can stall on RAW/WAW hazards.
module wb_arbiter #(
    parameter int DEPTH    = 2,
    parameter int MAX_WAIT = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        a_valid,
    input  logic [4:0]  a_addr,
    input  logic [31:0] a_data,
    input  logic        b_valid,
    output logic        b_ready,
    input  logic [4:0]  b_addr,
    input  logic [31:0] b_data,
    output logic        hold,
    input  logic        iss_valid,
    input  logic        iss_long,
    input  logic [4:0]  iss_rd,
    input  logic [4:0]  iss_ra1,
    input  logic [4:0]  iss_ra2,
    output logic        iss_stall,
    output logic        write_en,
    output logic [4:0]  wa,
    output logic [31:0] wd
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int AGE_W = $clog2(MAX_WAIT + 1);

    logic [4:0]       addrMem_q [DEPTH];
    logic [31:0]      dataMem_q [DEPTH];
    logic [PTR_W-1:0] wrPtr_q, wrPtr_d;
    logic [PTR_W-1:0] rdPtr_q, rdPtr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [AGE_W-1:0] age_q, age_d;
    logic             hold_q, hold_d;
    logic             writeEn_q, writeEn_d;
    logic [4:0]       wa_q, wa_d;
    logic [31:0]      wd_q, wd_d;
    logic [31:0]      busy_q, busy_d;

    logic             fifoEmpty;
    logic             push;
    logic             pop;
    logic             selValid;
    logic [4:0]       selAddr;
    logic [31:0]      selData;
    logic             headStarved;
    logic             holdSet;
    logic             busySet;

    // Port B may enter only while the FIFO has room; A always wins the write
    // port, so the head is popped only in cycles without an ALU result.
    assign fifoEmpty   = (count_q == '0);
    assign b_ready     = (count_q != CNT_W'(DEPTH));
    assign push        = b_valid && b_ready;
    assign pop         = !a_valid && !fifoEmpty;
    assign headStarved = !fifoEmpty && !pop;
    assign hold        = hold_q;
    assign write_en    = writeEn_q;
    assign wa          = wa_q;
    assign wd          = wd_q;

    // Busy bit 0 is never set, so reading x0 can never stall issue.
    assign iss_stall = iss_valid && (busy_q[iss_ra1] || busy_q[iss_ra2] || busy_q[iss_rd]);
    assign busySet   = iss_valid && iss_long && (iss_rd != 5'd0) && !iss_stall;

    // Pick the entry to be written this cycle: ALU first, then FIFO head.
    always_comb begin
        selValid = a_valid || pop;
        selAddr  = addrMem_q[rdPtr_q];
        selData  = dataMem_q[rdPtr_q];
        if (a_valid) begin
            selAddr = a_addr;
            selData = a_data;
        end
    end

    // Next-state logic for FIFO bookkeeping, write stage, aging, hold and scoreboard.
    always_comb begin
        wrPtr_d   = wrPtr_q;
        rdPtr_d   = rdPtr_q;
        count_d   = count_q;
        writeEn_d = selValid && (selAddr != 5'd0);
        wa_d      = wa_q;
        wd_d      = wd_q;
        age_d     = '0;
        hold_d    = hold_q;
        holdSet   = 1'b0;
        busy_d    = busy_q;

        if (push) begin
            wrPtr_d = wrPtr_q + PTR_W'(1);
        end
        if (pop) begin
            rdPtr_d = rdPtr_q + PTR_W'(1);
        end
        if (push && !pop) begin
            count_d = count_q + CNT_W'(1);
        end else if (pop && !push) begin
            count_d = count_q - CNT_W'(1);
        end

        if (writeEn_d) begin
            wa_d = selAddr;
            wd_d = selData;
        end

        if (headStarved) begin
            age_d = (age_q == AGE_W'(MAX_WAIT)) ? age_q : age_q + AGE_W'(1);
        end

        holdSet = (headStarved && (age_q == AGE_W'(MAX_WAIT - 1))) || !b_ready;
        if (holdSet) begin
            hold_d = 1'b1;
        end else if (pop) begin
            hold_d = 1'b0;
        end

        if (pop && (selAddr != 5'd0)) begin
            busy_d[selAddr] = 1'b0;
        end
        if (busySet) begin
            busy_d[iss_rd] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    // FIFO payload storage; contents are meaningless while count says empty.
    always_ff @(posedge clk) begin
        if (push) begin
            addrMem_q[wrPtr_q] <= b_addr;
            dataMem_q[wrPtr_q] <= b_data;
        end
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wrPtr_q   <= '0;
            rdPtr_q   <= '0;
            count_q   <= '0;
            age_q     <= '0;
            hold_q    <= 1'b0;
            writeEn_q <= 1'b0;
            wa_q      <= '0;
            wd_q      <= '0;
            busy_q    <= '0;
        end else begin
            wrPtr_q   <= wrPtr_d;
            rdPtr_q   <= rdPtr_d;
            count_q   <= count_d;
            age_q     <= age_d;
            hold_q    <= hold_d;
            writeEn_q <= writeEn_d;
            wa_q      <= wa_d;
            wd_q      <= wd_d;
            busy_q    <= busy_d;
        end
    end

endmodule

// File: tb/tb_wb_arbiter.sv
// Testbench for wb_arbiter: directed scenarios followed by random traffic,
// all compared against a queue-based behavioural model of the write-back rules.
module tb_wb_arbiter;

    localparam int DEPTH    = 2;
    localparam int MAX_WAIT = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        a_valid;
    logic [4:0]  a_addr;
    logic [31:0] a_data;
    logic        b_valid;
    logic        b_ready;
    logic [4:0]  b_addr;
    logic [31:0] b_data;
    logic        hold;
    logic        iss_valid;
    logic        iss_long;
    logic [4:0]  iss_rd;
    logic [4:0]  iss_ra1;
    logic [4:0]  iss_ra2;
    logic        iss_stall;
    logic        write_en;
    logic [4:0]  wa;
    logic [31:0] wd;

    int checkCount = 0;
    int failCount  = 0;

    typedef struct packed {
        logic [4:0]  addr;
        logic [31:0] data;
    } entry_t;

    // Reference model state
    entry_t      mQueue[$];
    int          mAge;
    bit          mHold;
    bit          mBusy[32];
    bit          mWe;
    logic [4:0]  mWa;
    logic [31:0] mWd;

    wb_arbiter #(.DEPTH(DEPTH), .MAX_WAIT(MAX_WAIT)) dut (
        .clk(clk), .rst_n(rst_n),
        .a_valid(a_valid), .a_addr(a_addr), .a_data(a_data),
        .b_valid(b_valid), .b_ready(b_ready), .b_addr(b_addr), .b_data(b_data),
        .hold(hold),
        .iss_valid(iss_valid), .iss_long(iss_long), .iss_rd(iss_rd),
        .iss_ra1(iss_ra1), .iss_ra2(iss_ra2), .iss_stall(iss_stall),
        .write_en(write_en), .wa(wa), .wd(wd)
    );

    // Free-running clock, period 10
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s at %0t: observed=%0h expected=%0h", tag, $time, observed, expected);
        end
    endtask

    task automatic modelReset();
        mQueue.delete();
        mAge  = 0;
        mHold = 1'b0;
        foreach (mBusy[i]) mBusy[i] = 1'b0;
        mWe   = 1'b0;
        mWa   = '0;
        mWd   = '0;
    endtask

    function automatic bit modelStall();
        return iss_valid && (mBusy[iss_ra1] || mBusy[iss_ra2] || mBusy[iss_rd]);
    endfunction

    // Advance the model by one clock edge using the inputs currently driven.
    task automatic modelStep();
        int     sizeBefore = mQueue.size();
        bit     popped     = !a_valid && (sizeBefore > 0);
        bit     starved    = (sizeBefore > 0) && !popped;
        bit     stall      = modelStall();
        bit     selValid   = 1'b0;
        bit     fromB      = 1'b0;
        bit     setHold;
        entry_t sel;
        sel = '0;
        if (a_valid) begin
            sel      = '{addr: a_addr, data: a_data};
            selValid = 1'b1;
        end else if (popped) begin
            sel      = mQueue.pop_front();
            selValid = 1'b1;
            fromB    = 1'b1;
        end
        mWe = selValid && (sel.addr != 0);
        if (mWe) begin
            mWa = sel.addr;
            mWd = sel.data;
        end
        if (fromB && sel.addr != 0) mBusy[sel.addr] = 1'b0;
        if (iss_valid && iss_long && iss_rd != 0 && !stall) mBusy[iss_rd] = 1'b1;
        setHold = (starved && mAge == MAX_WAIT - 1) || (sizeBefore == DEPTH);
        if (setHold) mHold = 1'b1;
        else if (popped) mHold = 1'b0;
        mAge = starved ? ((mAge < MAX_WAIT) ? mAge + 1 : MAX_WAIT) : 0;
        if (b_valid && sizeBefore < DEPTH) mQueue.push_back('{addr: b_addr, data: b_data});
    endtask

    // Drive one cycle of inputs, compare outputs mid-cycle, then step the model.
    task automatic applyStimulus(input bit av, input logic [4:0] aa, input logic [31:0] ad,
                                 input bit bv, input logic [4:0] ba, input logic [31:0] bd,
                                 input bit iv, input bit il, input logic [4:0] ird,
                                 input logic [4:0] ir1, input logic [4:0] ir2);
        @(posedge clk);
        #1;
        a_valid   = av && !mHold;
        a_addr    = mBusy[aa] ? 5'd0 : aa;
        a_data    = ad;
        b_valid   = bv;
        b_addr    = ba;
        b_data    = bd;
        iss_valid = iv;
        iss_long  = il;
        iss_rd    = ird;
        iss_ra1   = ir1;
        iss_ra2   = ir2;
        @(negedge clk);
        checkOutput("write_en", {31'd0, write_en}, {31'd0, mWe});
        if (mWe) begin
            checkOutput("wa", {27'd0, wa}, {27'd0, mWa});
            checkOutput("wd", wd, mWd);
        end
        checkOutput("hold", {31'd0, hold}, {31'd0, mHold});
        checkOutput("b_ready", {31'd0, b_ready}, {31'd0, mQueue.size() < DEPTH});
        checkOutput("iss_stall", {31'd0, iss_stall}, {31'd0, modelStall()});
        modelStep();
    endtask

    task automatic idleCycle();
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic probeCycle(input logic [4:0] ir1, input logic [4:0] ird);
        applyStimulus(0, 0, 0, 0, 0, 0, 1, 0, ird, ir1, 0);
    endtask

    task automatic setIdleInputs();
        a_valid = 0; a_addr = 0; a_data = 0;
        b_valid = 0; b_addr = 0; b_data = 0;
        iss_valid = 0; iss_long = 0; iss_rd = 0; iss_ra1 = 0; iss_ra2 = 0;
    endtask

    // Asynchronous reset mid-cycle; outputs must clear without waiting for an edge.
    task automatic doReset();
        @(posedge clk);
        #2;
        rst_n     = 1'b0;
        a_valid   = 1'b0;
        b_valid   = 1'b0;
        iss_valid = 1'b1;
        iss_ra1   = 5'd9;
        iss_ra2   = 5'd7;
        iss_rd    = 5'd12;
        #1;
        checkOutput("rst_write_en", {31'd0, write_en}, 32'd0);
        checkOutput("rst_wa", {27'd0, wa}, 32'd0);
        checkOutput("rst_wd", wd, 32'd0);
        checkOutput("rst_hold", {31'd0, hold}, 32'd0);
        checkOutput("rst_b_ready", {31'd0, b_ready}, 32'd1);
        checkOutput("rst_iss_stall", {31'd0, iss_stall}, 32'd0);
        setIdleInputs();
        modelReset();
        @(negedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0;
        setIdleInputs();
        modelReset();
        #12;
        rst_n = 1'b1;

        // A only: normal write, then a write to x0 that must be swallowed
        applyStimulus(1, 5, 32'hDEADBEEF, 0, 0, 0, 0, 0, 0, 0, 0);
        applyStimulus(1, 0, 32'h12345678, 0, 0, 0, 0, 0, 0, 0, 0);
        idleCycle();
        idleCycle();

        // Contention: long op to x7 issued, then A and B collide
        applyStimulus(0, 0, 0, 0, 0, 0, 1, 1, 7, 0, 0);
        applyStimulus(1, 3, 32'h11, 1, 7, 32'h22, 1, 0, 0, 7, 0);
        probeCycle(7, 0);
        probeCycle(7, 0);
        probeCycle(7, 0);
        probeCycle(7, 0);

        // Full FIFO and starvation: A every cycle while two B entries arrive
        applyStimulus(1, 1, 32'hA1, 1, 10, 32'hB10, 0, 0, 0, 0, 0);
        applyStimulus(1, 2, 32'hA2, 1, 11, 32'hB11, 0, 0, 0, 0, 0);
        applyStimulus(1, 3, 32'hA3, 1, 13, 32'hB13, 0, 0, 0, 0, 0);
        applyStimulus(1, 4, 32'hA4, 0, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 5; i++) idleCycle();

        // Scoreboard: long op to x9, RAW probes until its write lands
        applyStimulus(0, 0, 0, 0, 0, 0, 1, 1, 9, 0, 0);
        probeCycle(9, 0);
        probeCycle(0, 9);
        applyStimulus(0, 0, 0, 1, 9, 32'h99, 1, 0, 0, 9, 0);
        probeCycle(9, 0);
        probeCycle(9, 0);
        probeCycle(9, 0);
        probeCycle(0, 0);

        // Aging: one B entry starved by consecutive A results
        applyStimulus(1, 2, 32'hC0, 1, 12, 32'hCC, 0, 0, 0, 0, 0);
        for (int i = 0; i < 6; i++) applyStimulus(1, 6, 32'hC1 + i, 0, 0, 0, 0, 0, 0, 0, 0);
        idleCycle();
        idleCycle();

        // Reset in the middle of a burst with pending scoreboard entries
        applyStimulus(0, 0, 0, 0, 0, 0, 1, 1, 9, 0, 0);
        applyStimulus(1, 4, 32'h44, 1, 9, 32'h55, 1, 1, 7, 0, 0);
        applyStimulus(1, 5, 32'h66, 1, 7, 32'h77, 0, 0, 0, 0, 0);
        doReset();
        probeCycle(9, 7);
        idleCycle();

        // Random traffic
        for (int i = 0; i < 600; i++) begin
            applyStimulus($urandom_range(0, 9) < 7, 5'($urandom), $urandom,
                          $urandom_range(0, 1) == 1, 5'($urandom), $urandom,
                          $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
                          5'($urandom), 5'($urandom), 5'($urandom));
        end
        for (int i = 0; i < 6; i++) idleCycle();

        $display("End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
        $finish;
    end

endmodule
